card_dealer: RTL and testbench

Card source for the blackjack game. On each draw request it produces one card from a 52-card deck without repeats, using a free-running LFSR and a linear probe over a used-card mask. The block sits directly upstream of the game-sequencing FSM, which requests one card in each of its deal and turn states. It also serves the downstream hand scorer.

---
 rtl/blackjack_pkg.sv | 62 ++++++
 rtl/dealer_lfsr.sv | 34 +++
 rtl/card_dealer.sv | 169 ++++++++++++++++
 tb/tb_card_dealer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// -----------------------------------------------------------------------------
// blackjack_pkg
//   Shared definitions for the blackjack datapath: the card dealer, the game
//   sequencing FSM and the hand scorer all import this package.
//
//   Contents:
//     DECK_SIZE, RANKS      deck geometry (52 cards, 13 ranks per suit)
//     rank_t, suit_t        card field types (rank 1..13, suit 0..3)
//     card_t                packed rank/suit/blackjack value bundle
//     dealer_state_t        card_dealer FSM state encoding
//     fold_candidate()      map a 6-bit random draw onto 0..51
//     index_to_card()       map a deck index 0..51 onto rank/suit/value
// -----------------------------------------------------------------------------
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  typedef logic [3:0] rank_t;
  typedef logic [1:0] suit_t;

  typedef struct packed {
    rank_t      rank;
    suit_t      suit;
    logic [3:0] value;
  } card_t;

  typedef enum logic [1:0] {
    DLR_IDLE  = 2'd0,
    DLR_PROBE = 2'd1,
    DLR_EMIT  = 2'd2
  } dealer_state_t;

  // 0..63 onto 0..51: the top twelve codes wrap back to the start of the deck.
  function automatic logic [5:0] fold_candidate(input logic [5:0] raw);
    return (raw >= 6'(DECK_SIZE)) ? (raw - 6'(DECK_SIZE)) : raw;
  endfunction

  // Deck index i: suit = i / 13, rank = (i mod 13) + 1, value = min(rank, 10).
  // A compare ladder avoids a general divider for the constant 13.
  function automatic card_t index_to_card(input logic [5:0] idx);
    card_t      c;
    logic [5:0] r;
    if (idx < 6'(RANKS)) begin
      c.suit = 2'd0;
      r      = idx;
    end else if (idx < 6'(2 * RANKS)) begin
      c.suit = 2'd1;
      r      = idx - 6'(RANKS);
    end else if (idx < 6'(3 * RANKS)) begin
      c.suit = 2'd2;
      r      = idx - 6'(2 * RANKS);
    end else begin
      c.suit = 2'd3;
      r      = idx - 6'(3 * RANKS);
    end
    c.rank  = rank_t'(r + 6'd1);
    c.value = (c.rank > 4'd10) ? 4'd10 : c.rank;
    return c;
  endfunction

endpackage

// File: rtl/dealer_lfsr.sv
// -----------------------------------------------------------------------------
// dealer_lfsr
//   Free-running right-shifting Galois LFSR. When the bit shifted out is 1 the
//   tap mask is XORed into the shifted value. The register never stalls.
//
//   Parameters:
//     WIDTH   register width
//     SEED    value loaded by reset (must be non-zero)
//     TAPS    Galois feedback mask
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   asynchronous, active-high; loads SEED
//     state   out  current register value
//     next    out  value the register takes on the next edge
// -----------------------------------------------------------------------------
module dealer_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  assign next = state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEED;
    else       state <= next;
  end

endmodule

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//   Card source for the blackjack game. Each accepted draw request yields one
//   card picked by a free-running LFSR. With DEALER_NO_REPEAT_EN defined the
//   deck is drawn without replacement: a used-card mask is linearly probed from
//   the random candidate until a free card is found. Without the macro the
//   dealer is an infinite shoe: every candidate is accepted, the deck count is
//   fixed at 52 and shuffle has no effect.
//
//   Configuration macro: DEALER_NO_REPEAT_EN
//
//   Parameters:
//     LFSR_WIDTH  LFSR width (>= 6)
//     SEED        LFSR reset value (non-zero)
//   Ports:
//     clk         in   clock, rising edge
//     reset       in   asynchronous, active-high
//     draw_req    in   request one card (sampled while draw_ready=1)
//     shuffle     in   single-cycle pulse: return all cards to the deck
//     draw_ready  out  idle and accepting draw_req
//     card_valid  out  one-cycle pulse, card outputs valid
//     card_rank   out  1..13 (A=1, J=11, Q=12, K=13), held until next card
//     card_suit   out  0..3, held until next card
//     card_value  out  blackjack value (A=1, J/Q/K=10), held until next card
//     cards_left  out  cards remaining in the deck, 0..52
//     deck_empty  out  cards_left == 0
// -----------------------------------------------------------------------------
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(16'hACE1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  input  logic       shuffle,
  output logic       draw_ready,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_WIDTH'(16'hB400);

  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [5:0]            cand;
  logic [5:0]            idx;
  card_t                 probe_card;
  dealer_state_t         state;
  logic                  unused_bits;

`ifdef DEALER_NO_REPEAT_EN
  logic [DECK_SIZE-1:0]  used;
  logic                  shuffle_pend;
`endif

  dealer_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state),
    .next  (lfsr_next)
  );

  // The LFSR keeps running through every state, so the candidate depends on
  // exactly which cycle the request lands in.
  assign cand       = fold_candidate(lfsr_state[5:0]);
  assign probe_card = index_to_card(idx);
  assign deck_empty = (cards_left == 6'd0);

`ifdef DEALER_NO_REPEAT_EN
  assign unused_bits = ^{lfsr_state, lfsr_next};
`else
  assign unused_bits = ^{lfsr_state, lfsr_next, shuffle};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= DLR_IDLE;
      idx          <= 6'd0;
      draw_ready   <= 1'b1;
      card_valid   <= 1'b0;
      card_rank    <= 4'd0;
      card_suit    <= 2'd0;
      card_value   <= 4'd0;
      cards_left   <= 6'(DECK_SIZE);
`ifdef DEALER_NO_REPEAT_EN
      used         <= '0;
      shuffle_pend <= 1'b0;
`endif
    end else begin
      card_valid <= 1'b0;
      case (state)
        DLR_IDLE: begin
`ifdef DEALER_NO_REPEAT_EN
          // A shuffle (fresh or left pending from a draw) wins over a draw in
          // the same cycle. In the pending case draw_ready is already low.
          if (shuffle_pend || shuffle) begin
            used         <= '0;
            cards_left   <= 6'(DECK_SIZE);
            shuffle_pend <= 1'b0;
            draw_ready   <= 1'b1;
          end else if (draw_req && !deck_empty) begin
            idx        <= cand;
            state      <= DLR_PROBE;
            draw_ready <= 1'b0;
          end
`else
          if (draw_req) begin
            idx        <= cand;
            state      <= DLR_PROBE;
            draw_ready <= 1'b0;
          end
`endif
        end

        DLR_PROBE: begin
`ifdef DEALER_NO_REPEAT_EN
          if (shuffle) shuffle_pend <= 1'b1;
          // PROBE is only entered with a non-empty deck, so the walk always
          // finds a free card within 52 steps.
          if (!used[idx]) begin
            used[idx]  <= 1'b1;
            cards_left <= cards_left - 6'd1;
            card_rank  <= probe_card.rank;
            card_suit  <= probe_card.suit;
            card_value <= probe_card.value;
            card_valid <= 1'b1;
            state      <= DLR_EMIT;
          end else begin
            idx <= (idx == 6'(DECK_SIZE - 1)) ? 6'd0 : (idx + 6'd1);
          end
`else
          card_rank  <= probe_card.rank;
          card_suit  <= probe_card.suit;
          card_value <= probe_card.value;
          card_valid <= 1'b1;
          state      <= DLR_EMIT;
`endif
        end

        DLR_EMIT: begin
          state <= DLR_IDLE;
`ifdef DEALER_NO_REPEAT_EN
          // Hold off new draws for one IDLE cycle if a shuffle is owed.
          shuffle_pend <= shuffle_pend | shuffle;
          draw_ready   <= !(shuffle_pend || shuffle);
`else
          draw_ready   <= 1'b1;
`endif
        end

        default: begin
          state      <= DLR_IDLE;
          draw_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
//   Directed-sequence bench with random request timing. A reference model of
//   the deck (LFSR sequence, candidate fold, linear probe over a used array)
//   predicts each card, its latency and the deck count. Build with or without
//   DEALER_NO_REPEAT_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       draw_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       draw_ready;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       deck_empty;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned m_lfsr;
  bit          m_used [52];
  int          m_left;

  card_dealer dut (
    .clk        (clk),
    .reset      (reset),
    .draw_req   (draw_req),
    .shuffle    (shuffle),
    .draw_ready (draw_ready),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_suit  (card_suit),
    .card_value (card_value),
    .cards_left (cards_left),
    .deck_empty (deck_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, required finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned lfsr_step(input int unsigned s);
    if ((s & 1) != 0) return (s >> 1) ^ 32'h0000B400;
    return s >> 1;
  endfunction

  function automatic int cand_of(input int unsigned s);
    int c;
    c = int'(s % 64);
    if (c >= 52) c = c - 52;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_lfsr = 32'h0000ACE1;
    else       m_lfsr = lfsr_step(m_lfsr);
    #1;
  endtask

  task automatic model_full();
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  task automatic idle_gap(input int max_cycles);
    repeat ($urandom_range(0, max_cycles)) tick();
  endtask

  // One draw from IDLE. Returns the deck index reconstructed from the DUT's
  // outputs (or -1 if no card arrived).
  task automatic draw(input bit shuf_in_probe, output int dut_idx);
    int          c;
    int          probes;
    int          waited;
    int          er;
    bit          got;
    bit          ready_leak;
    int unsigned pre;
    check("ready_before_draw", 32'(draw_ready), 32'd1);
    pre      = m_lfsr;
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    c      = cand_of(pre);
    probes = 1;
`ifdef DEALER_NO_REPEAT_EN
    while (m_used[c]) begin
      c = (c == 51) ? 0 : c + 1;
      probes++;
    end
`endif
    if (shuf_in_probe) shuffle = 1'b1;
    waited     = 0;
    got        = 1'b0;
    ready_leak = 1'b0;
    while (waited < 60 && !got) begin
      if (draw_ready) ready_leak = 1'b1;
      tick();
      shuffle = 1'b0;
      waited++;
      if (card_valid) got = 1'b1;
    end
    er = (c % 13) + 1;
    check("valid_seen", 32'(got), 32'd1);
    check("latency_cycles", 32'(waited + 1), 32'(probes + 1));
    check("ready_low_busy", 32'(ready_leak | draw_ready), 32'd0);
    check("rank", 32'(card_rank), 32'(er));
    check("suit", 32'(card_suit), 32'(c / 13));
    check("value", 32'(card_value), 32'((er > 10) ? 10 : er));
`ifdef DEALER_NO_REPEAT_EN
    m_used[c] = 1'b1;
    m_left--;
`endif
    check("cards_left", 32'(cards_left), 32'(m_left));
    check("deck_empty", 32'(deck_empty), 32'(m_left == 0));
    dut_idx = got ? (int'(card_suit) * 13 + int'(card_rank) - 1) : -1;
    tick();
    check("valid_one_cycle", 32'(card_valid), 32'd0);
    check("rank_held", 32'(card_rank), 32'(er));
    if (!shuf_in_probe) check("ready_after_emit", 32'(draw_ready), 32'd1);
  endtask

  task automatic wait_cand(input int target);
    int n;
    n = 0;
    while (cand_of(m_lfsr) != target && n < 2000) begin
      tick();
      n++;
    end
    check("cand_reachable", 32'(n < 2000), 32'd1);
  endtask

  int tgt [3] = '{11, 0, 22};
  int t_rk[3] = '{12, 1, 10};
  int t_st[3] = '{0, 0, 1};
  int t_vl[3] = '{10, 1, 10};

  initial begin
    int  d;
    int  distinct;
    bit  seen [52];
    bit  stray;

    m_lfsr = 32'h0000ACE1;
    model_full();
    tick();
    tick();
    check("rst_ready", 32'(draw_ready), 32'd1);
    check("rst_valid", 32'(card_valid), 32'd0);
    check("rst_rank", 32'(card_rank), 32'd0);
    check("rst_suit", 32'(card_suit), 32'd0);
    check("rst_value", 32'(card_value), 32'd0);
    check("rst_cards_left", 32'(cards_left), 32'd52);
    check("rst_deck_empty", 32'(deck_empty), 32'd0);
    #2 reset = 1'b0;

    // Basic draw.
    idle_gap(7);
    draw(1'b0, d);
    check("basic_rank_range", 32'(card_rank >= 4'd1 && card_rank <= 4'd13), 32'd1);

`ifdef DEALER_NO_REPEAT_EN
    // Drain the whole deck.
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    if (d >= 0 && d < 52) begin
      seen[d]  = 1'b1;
      distinct = 1;
    end
    for (int k = 1; k < 52; k++) begin
      idle_gap(3);
      draw(1'b0, d);
      if (d >= 0 && d < 52 && !seen[d]) begin
        seen[d] = 1'b1;
        distinct++;
      end
    end
    check("distinct_cards", 32'(distinct), 32'd52);
    check("empty_cards_left", 32'(cards_left), 32'd0);
    check("empty_flag", 32'(deck_empty), 32'd1);

    // A request against an empty deck is ignored.
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    stray = 1'b0;
    repeat (100) begin
      tick();
      if (card_valid) stray = 1'b1;
    end
    check("no_card_when_empty", 32'(stray), 32'd0);
    check("ready_when_empty", 32'(draw_ready), 32'd1);

    // Shuffle from IDLE.
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    model_full();
    check("shuffle_cards_left", 32'(cards_left), 32'd52);
    check("shuffle_not_empty", 32'(deck_empty), 32'd0);
    draw(1'b0, d);

    // Shuffle while probing: card delivered, deck refilled one IDLE cycle later.
    idle_gap(4);
    draw(1'b1, d);
    check("pend_ready_low", 32'(draw_ready), 32'd0);
    check("pend_cards_left", 32'(cards_left), 32'(m_left));
    tick();
    model_full();
    check("pend_applied_left", 32'(cards_left), 32'd52);
    check("pend_ready_back", 32'(draw_ready), 32'd1);
`else
    // Infinite shoe: 59 more draws with idle shuffles that must be ignored.
    for (int k = 1; k < 60; k++) begin
      idle_gap(3);
      if ($urandom_range(0, 3) == 0) begin
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        check("shoe_shuffle_ignored", 32'(cards_left), 32'd52);
        check("shoe_ready", 32'(draw_ready), 32'd1);
      end
      draw(1'b0, d);
    end
`endif

    // Value mapping at chosen deck indices.
    for (int k = 0; k < 3; k++) begin
      wait_cand(tgt[k]);
      draw(1'b0, d);
      check("map_index", 32'(d), 32'(tgt[k]));
      check("map_rank", 32'(card_rank), 32'(t_rk[k]));
      check("map_suit", 32'(card_suit), 32'(t_st[k]));
      check("map_value", 32'(card_value), 32'(t_vl[k]));
    end

    // Reset while a draw is in PROBE.
    idle_gap(3);
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    reset  = 1'b1;
    m_lfsr = 32'h0000ACE1;
    #1;
    check("midrst_ready", 32'(draw_ready), 32'd1);
    check("midrst_valid", 32'(card_valid), 32'd0);
    check("midrst_rank", 32'(card_rank), 32'd0);
    check("midrst_suit", 32'(card_suit), 32'd0);
    check("midrst_value", 32'(card_value), 32'd0);
    check("midrst_cards_left", 32'(cards_left), 32'd52);
    check("midrst_deck_empty", 32'(deck_empty), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    model_full();
    stray = 1'b0;
    repeat (60) begin
      tick();
      if (card_valid) stray = 1'b1;
    end
    check("midrst_no_valid", 32'(stray), 32'd0);
    check("midrst_full_deck", 32'(cards_left), 32'd52);

    // Normal operation resumes from the reset seed.
    for (int k = 0; k < 4; k++) begin
      idle_gap(5);
      draw(1'b0, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
